fwd_hazard_unit: RTL

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand-forward selects and stall/flush control
// for a 5-stage RISC-V pipeline (D, E, M, W shadows kept here).
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   rs1_d, rs2_d, rd_d    decode-stage register indices
//   regwrite_d, valid_d   decode-stage write enable / real instr
//   resultsrc_d           00 ALU, 01 load, 10 PC+4, 11 reserved
//   pcsrc_e               taken branch/jump resolved in execute
//   fwd_a_e, fwd_b_e      00 regfile, 01 WB, 10 MEM ALU, 11 MEM PC+4
//   stall_f, stall_d      hold fetch / decode registers
//   flush_d, flush_e      clear decode / execute registers
//   stall_cnt, flush_cnt  perf counters, only with HAZARD_PERF_EN
module fwd_hazard_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rd_d,
  input  logic        regwrite_d,
  input  logic        valid_d,
  input  logic [1:0]  resultsrc_d,
  input  logic        pcsrc_e,
  output logic [1:0]  fwd_a_e,
  output logic [1:0]  fwd_b_e,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        flush_e
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ex_sh_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
    logic [1:0] resultsrc;
  } wr_sh_t;

  localparam logic [1:0] RS_LOAD = 2'b01;
  localparam logic [1:0] RS_PC4  = 2'b10;
  localparam logic [1:0] RS_RSV  = 2'b11;

  localparam logic [1:0] FW_RF  = 2'b00;
  localparam logic [1:0] FW_WB  = 2'b01;
  localparam logic [1:0] FW_MEM = 2'b10;
  localparam logic [1:0] FW_PC4 = 2'b11;

  ex_sh_t e_q, e_d;
  wr_sh_t m_q, m_d;
  wr_sh_t w_q, w_d;

  logic lw_stall;

  // Load in E whose result a real instruction in D needs:
  // the value only exists after M, so D must wait one cycle.
  always_comb begin
    lw_stall = 1'b0;
    if (valid_d && e_q.regwrite &&
        (e_q.resultsrc == RS_LOAD) &&
        (e_q.rd != 5'd0) &&
        ((e_q.rd == rs1_d) || (e_q.rd == rs2_d)))
      lw_stall = 1'b1;
  end

  // Outputs are forced idle while reset is held so that
  // a live pcsrc_e cannot leak a flush out of reset.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (rst_n) begin
      if (pcsrc_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lw_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input wr_sh_t     m,
    input wr_sh_t     w
  );
    logic [1:0] sel;
    sel = FW_RF;
    if (m.regwrite && (m.rd != 5'd0) && (m.rd == rs))
      sel = (m.resultsrc == RS_PC4) ? FW_PC4 : FW_MEM;
    else if (w.regwrite && (w.rd != 5'd0) && (w.rd == rs))
      sel = FW_WB;
    return sel;
  endfunction

  always_comb begin
    fwd_a_e = fwd_sel(e_q.rs1, m_q, w_q);
    fwd_b_e = fwd_sel(e_q.rs2, m_q, w_q);
  end

  always_comb begin
    e_d = '0;
    if (!flush_e) begin
      e_d.rd        = rd_d;
      e_d.regwrite  = regwrite_d;
      e_d.resultsrc = resultsrc_d;
      e_d.rs1       = rs1_d;
      e_d.rs2       = rs2_d;
    end
    m_d.rd        = e_q.rd;
    m_d.regwrite  = e_q.regwrite;
    m_d.resultsrc = e_q.resultsrc;
    w_d           = m_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall_d};
    flush_cnt_d = flush_cnt_q + {31'd0, flush_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

  // A load still in M with a consumer in E means the
  // load-use stall was missed; there is no mux input for it.
  a_no_load_use_in_m: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(m_q.regwrite && (m_q.resultsrc == RS_LOAD) &&
      (m_q.rd != 5'd0) &&
      ((m_q.rd == e_q.rs1) || (m_q.rd == e_q.rs2))));

  // The reserved result source must never reach writeback.
  a_no_rsv_src: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(w_q.regwrite && (w_q.resultsrc == RS_RSV)));

endmodule
